sfr_bank: RTL and testbench

- Parametrised 8051 special-function-register bank; successor to the fixed per-register SFR file.
- Holds N_SFR byte registers at a configurable sparse direct-address map (0x80–0xFF).
- Provides one CPU byte-write port, one bit-operation port (SETB/CLR/CPL) on bit-addressable SFRs, a registered read port and per-register hardware update ports.
- Maintains the PSW parity flag from ACC automatically; sits between decode/ALU and peripherals (timers, UART, ports).

---
 rtl/sfr_pkg.sv | 79 +++++++
 rtl/sfr_cell.sv | 38 +++
 rtl/sfr_bank.sv | 182 ++++++++++++++++++
 tb/tb_sfr_bank.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sfr_pkg.sv
// Shared constants, types and next-value helper for the 8051 SFR bank.
// The timed-access types are used only when SFR_TIMED_ACCESS_EN is defined.
package sfr_pkg;

  localparam logic [7:0] AddrAcc  = 8'hE0;
  localparam logic [7:0] AddrPsw  = 8'hD0;
  localparam logic [7:0] AddrSp   = 8'h81;
  localparam logic [7:0] AddrIe   = 8'hA8;
  localparam logic [7:0] AddrTmod = 8'h89;
  localparam logic [7:0] AddrTcon = 8'h88;
  localparam logic [7:0] AddrTl0  = 8'h8A;
  localparam logic [7:0] AddrTh0  = 8'h8C;
  localparam logic [7:0] AddrScon = 8'h98;
  localparam logic [7:0] AddrSbuf = 8'h99;
  localparam logic [7:0] AddrP2   = 8'hA0;
  localparam logic [7:0] AddrB    = 8'hF0;
  localparam logic [7:0] AddrTa   = 8'hC7;

  localparam logic [7:0] RstSp    = 8'h07;
  localparam logic [7:0] RstP2    = 8'hFF;
  localparam logic [7:0] RstZero  = 8'h00;

  localparam int unsigned NSfrDefault = 12;

  // Index 0 sits in the least significant byte.
  localparam logic [NSfrDefault*8-1:0] SfrAddrsDefault = {
    AddrB, AddrP2, AddrSbuf, AddrScon, AddrTh0, AddrTl0,
    AddrTcon, AddrTmod, AddrIe, AddrSp, AddrPsw, AddrAcc
  };

  localparam logic [NSfrDefault*8-1:0] SfrRstvDefault = {
    RstZero, RstP2, RstZero, RstZero, RstZero, RstZero,
    RstZero, RstZero, RstZero, RstSp, RstZero, RstZero
  };

  typedef enum logic [1:0] {
    BopNone = 2'b00,
    BopSetb = 2'b01,
    BopClr  = 2'b10,
    BopCpl  = 2'b11
  } bop_e;

  typedef enum logic [1:0] {
    StLocked = 2'b00,
    StArmed  = 2'b01,
    StOpen   = 2'b10
  } ta_state_e;

  function automatic logic bit_addressable(input logic [7:0] addr);
    return (addr & 8'h07) == 8'h00;
  endfunction

  // Priority: byte write, bit op, hardware update, hold.
  function automatic logic [7:0] sfr_next(
    input logic [7:0] q,
    input logic       byte_we,
    input logic [7:0] wdata,
    input logic       bop_en,
    input bop_e       bop,
    input logic [2:0] bidx,
    input logic       hw_we,
    input logic [7:0] hw_data
  );
    logic [7:0] mask;
    mask = 8'h01 << bidx;
    if (byte_we) return wdata;
    if (bop_en) begin
      case (bop)
        BopSetb: return q | mask;
        BopClr:  return q & ~mask;
        BopCpl:  return q ^ mask;
        default: return q;
      endcase
    end
    if (hw_we) return hw_data;
    return q;
  endfunction

endpackage

// File: rtl/sfr_cell.sv
// One 8-bit special-function register: reset value, write priority mux,
// write-protect gate and forced bits (used for the PSW parity flag).
module sfr_cell
  import sfr_pkg::*;
#(
  parameter logic [7:0] RstVal = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       byte_we_i,
  input  logic [7:0] wdata_i,
  input  logic       bop_en_i,
  input  bop_e       bop_i,
  input  logic [2:0] bidx_i,
  input  logic       hw_we_i,
  input  logic [7:0] hw_data_i,
  input  logic       lock_i,
  input  logic [7:0] force_mask_i,
  input  logic [7:0] force_val_i,
  output logic [7:0] q_o
);

  logic [7:0] q_q, q_d;

  always_comb begin
    q_d = sfr_next(q_q, byte_we_i & ~lock_i, wdata_i, bop_en_i & ~lock_i, bop_i, bidx_i,
                   hw_we_i, hw_data_i);
    q_d = (q_d & ~force_mask_i) | (force_val_i & force_mask_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= RstVal;
    else         q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/sfr_bank.sv
// Parametrised 8051 SFR bank with byte/bit CPU ports, registered reads and PSW parity.
// Define SFR_TIMED_ACCESS_EN to add the TA register (0xC7) guarding PROT_MASK registers.
module sfr_bank
  import sfr_pkg::*;
#(
  parameter int unsigned        N_SFR     = NSfrDefault,
  parameter logic [N_SFR*8-1:0] SFR_ADDRS = SfrAddrsDefault,
  parameter logic [N_SFR*8-1:0] SFR_RSTV  = SfrRstvDefault,
  parameter int unsigned        ACC_IDX   = 0,
  parameter int unsigned        PSW_IDX   = 1
`ifdef SFR_TIMED_ACCESS_EN
  ,
  parameter logic [N_SFR-1:0]   PROT_MASK = '0
`endif
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_we,
  input  logic [7:0]           i_waddr,
  input  logic [7:0]           i_wdata,
  input  logic [1:0]           i_bop,
  input  logic [7:0]           i_baddr,
  input  logic [7:0]           i_raddr,
  input  logic [7:0]           i_rbaddr,
  output logic [7:0]           o_rdata,
  output logic                 o_rbit,
  output logic                 o_rerr,
  output logic                 o_coll,
  input  logic [N_SFR-1:0]     i_hw_we,
  input  logic [N_SFR*8-1:0]   i_hw_data,
  output logic [N_SFR*8-1:0]   o_sfr,
  output logic                 o_parity
);

  bop_e               bop;
  logic               bop_act;
  logic [N_SFR*8-1:0] sfr_q;
  logic [N_SFR-1:0]   wr_hit, bop_hit, bop_en, lock;
  logic               wr_found, bop_found, bop_ok, rd_found, rb_match, rb_ok;
  logic [7:0]         addr, rd_val;
  logic               rb_val, ta_wr, err, coll;
  logic [7:0]         acc_next;
  logic               acc_par;
  logic [7:0]         rdata_q;
  logic               rbit_q, rerr_q, coll_q;

  assign bop     = bop_e'(i_bop);
  assign bop_act = (bop != BopNone);

  // Lowest index wins on duplicate addresses.
  always_comb begin
    wr_hit    = '0;
    bop_hit   = '0;
    wr_found  = 1'b0;
    bop_found = 1'b0;
    bop_ok    = 1'b0;
    rd_found  = 1'b0;
    rb_match  = 1'b0;
    rb_ok     = 1'b0;
    rd_val    = 8'h00;
    rb_val    = 1'b0;
    addr      = 8'h00;
    for (int i = 0; i < N_SFR; i++) begin
      addr = SFR_ADDRS[8*i +: 8];
      if (!wr_found && addr == i_waddr) begin
        wr_found  = 1'b1;
        wr_hit[i] = i_we;
      end
      if (!bop_found && addr == {i_baddr[7:3], 3'b000}) begin
        bop_found  = 1'b1;
        bop_ok     = bit_addressable(addr);
        bop_hit[i] = bop_act & bit_addressable(addr);
      end
      if (!rd_found && addr == i_raddr) begin
        rd_found = 1'b1;
        rd_val   = sfr_q[8*i +: 8];
      end
      if (!rb_match && addr == {i_rbaddr[7:3], 3'b000}) begin
        rb_match = 1'b1;
        rb_ok    = bit_addressable(addr);
        rb_val   = bit_addressable(addr) & sfr_q[8*i + int'(i_rbaddr[2:0])];
      end
    end
  end

  // A bit op colliding with a byte write on the same register is dropped.
  assign bop_en = bop_hit & ~wr_hit;
  assign coll   = |(wr_hit & bop_hit);

`ifdef SFR_TIMED_ACCESS_EN
  ta_state_e ta_q;
  logic [1:0] ta_cnt_q;

  assign ta_wr = i_we && (i_waddr == AddrTa);
  assign lock  = PROT_MASK & {N_SFR{ta_q != StOpen}};

  // OPEN lasts four cycles: the counter runs 3..0 while open.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ta_q     <= StLocked;
      ta_cnt_q <= 2'd0;
    end else begin
      case (ta_q)
        StLocked: if (ta_wr && i_wdata == 8'hAA) ta_q <= StArmed;
        StArmed: begin
          if (ta_wr && i_wdata == 8'h55) begin
            ta_q     <= StOpen;
            ta_cnt_q <= 2'd3;
          end else begin
            ta_q <= StLocked;
          end
        end
        StOpen: begin
          if (ta_wr || ta_cnt_q == 2'd0) ta_q <= StLocked;
          else                           ta_cnt_q <= ta_cnt_q - 2'd1;
        end
        default: ta_q <= StLocked;
      endcase
    end
  end
`else
  assign ta_wr = 1'b0;
  assign lock  = '0;
`endif

  assign err = (i_we & ~wr_found & ~ta_wr) | (bop_act & ~bop_ok) | ~rd_found
             | ~(rb_match & rb_ok) | (|((wr_hit | bop_en) & lock));

  // PSW.P tracks the ACC value being loaded this cycle.
  always_comb begin
    acc_next = sfr_next(sfr_q[8*ACC_IDX +: 8], wr_hit[ACC_IDX] & ~lock[ACC_IDX], i_wdata,
                        bop_en[ACC_IDX] & ~lock[ACC_IDX], bop, i_baddr[2:0],
                        i_hw_we[ACC_IDX], i_hw_data[8*ACC_IDX +: 8]);
  end
  assign acc_par = ^acc_next;

  for (genvar g = 0; g < N_SFR; g++) begin : g_cell
    localparam logic [7:0] RstVal = (g == PSW_IDX) ?
        {SFR_RSTV[8*g+1 +: 7], ^SFR_RSTV[8*ACC_IDX +: 8]} : SFR_RSTV[8*g +: 8];
    localparam logic [7:0] ForceMask = (g == PSW_IDX) ? 8'h01 : 8'h00;

    sfr_cell #(
      .RstVal(RstVal)
    ) u_cell (
      .clk_i       (i_clk),
      .rst_ni      (i_rst),
      .byte_we_i   (wr_hit[g]),
      .wdata_i     (i_wdata),
      .bop_en_i    (bop_en[g]),
      .bop_i       (bop),
      .bidx_i      (i_baddr[2:0]),
      .hw_we_i     (i_hw_we[g]),
      .hw_data_i   (i_hw_data[8*g +: 8]),
      .lock_i      (lock[g]),
      .force_mask_i(ForceMask),
      .force_val_i ({7'b0, acc_par}),
      .q_o         (sfr_q[8*g +: 8])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rdata_q <= 8'h00;
      rbit_q  <= 1'b0;
      rerr_q  <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      rdata_q <= rd_val;
      rbit_q  <= rb_val;
      rerr_q  <= err;
      coll_q  <= coll;
    end
  end

  assign o_sfr    = sfr_q;
  assign o_rdata  = rdata_q;
  assign o_rbit   = rbit_q;
  assign o_rerr   = rerr_q;
  assign o_coll   = coll_q;
  assign o_parity = ^sfr_q[8*ACC_IDX +: 8];

endmodule

// File: tb/tb_sfr_bank.sv
// Randomised self-checking bench for sfr_bank (default map, no timed access)
// against an address-table reference model.
module tb_sfr_bank;

  localparam int NREG = 12;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b0;
  logic              i_we;
  logic [7:0]        i_waddr, i_wdata;
  logic [1:0]        i_bop;
  logic [7:0]        i_baddr, i_raddr, i_rbaddr;
  logic [7:0]        o_rdata;
  logic              o_rbit, o_rerr, o_coll, o_parity;
  logic [NREG-1:0]   i_hw_we;
  logic [NREG*8-1:0] i_hw_data;
  logic [NREG*8-1:0] o_sfr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] addr_tbl [NREG];
  logic [7:0] rst_tbl  [NREG];
  logic [7:0] mdl      [NREG];

  sfr_bank u_dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_we     (i_we),
    .i_waddr  (i_waddr),
    .i_wdata  (i_wdata),
    .i_bop    (i_bop),
    .i_baddr  (i_baddr),
    .i_raddr  (i_raddr),
    .i_rbaddr (i_rbaddr),
    .o_rdata  (o_rdata),
    .o_rbit   (o_rbit),
    .o_rerr   (o_rerr),
    .o_coll   (o_coll),
    .i_hw_we  (i_hw_we),
    .i_hw_data(i_hw_data),
    .o_sfr    (o_sfr),
    .o_parity (o_parity)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int find(input logic [7:0] a);
    for (int i = 0; i < NREG; i++) if (addr_tbl[i] == a) return i;
    return -1;
  endfunction

  function automatic int bit_reg(input logic [7:0] b);
    int idx;
    idx = find({b[7:3], 3'b000});
    if (idx >= 0 && (addr_tbl[idx][3:0] == 4'h0 || addr_tbl[idx][3:0] == 4'h8)) return idx;
    return -1;
  endfunction

  function automatic logic [95:0] flat();
    logic [95:0] f;
    for (int i = 0; i < NREG; i++) f[8*i +: 8] = mdl[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) mdl[i] = rst_tbl[i];
    mdl[1][0] = ^mdl[0];
  endtask

  task automatic idle();
    i_we      = 1'b0;
    i_waddr   = 8'h00;
    i_wdata   = 8'h00;
    i_bop     = 2'b00;
    i_baddr   = 8'hE0;
    i_raddr   = 8'hE0;
    i_rbaddr  = 8'hE0;
    i_hw_we   = '0;
    i_hw_data = '0;
  endtask

  // Predict one clock from the current inputs, advance, then compare.
  task automatic step();
    logic [7:0] nxt [NREG];
    int wi, bi, ri, rbi;
    logic [7:0] exp_rdata;
    logic exp_rbit, exp_err, exp_coll;
    wi  = i_we ? find(i_waddr) : -1;
    bi  = (i_bop != 2'b00) ? bit_reg(i_baddr) : -1;
    ri  = find(i_raddr);
    rbi = bit_reg(i_rbaddr);
    exp_rdata = (ri >= 0) ? mdl[ri] : 8'h00;
    exp_rbit  = (rbi >= 0) ? mdl[rbi][i_rbaddr[2:0]] : 1'b0;
    exp_err   = (i_we && find(i_waddr) < 0) || (i_bop != 2'b00 && bi < 0) || ri < 0 || rbi < 0;
    exp_coll  = (wi >= 0) && (bi == wi);
    nxt = mdl;
    for (int i = 0; i < NREG; i++) if (i_hw_we[i]) nxt[i] = i_hw_data[8*i +: 8];
    if (bi >= 0 && bi != wi) begin
      nxt[bi] = mdl[bi];
      case (i_bop)
        2'b01:   nxt[bi][i_baddr[2:0]] = 1'b1;
        2'b10:   nxt[bi][i_baddr[2:0]] = 1'b0;
        default: nxt[bi][i_baddr[2:0]] = ~mdl[bi][i_baddr[2:0]];
      endcase
    end
    if (wi >= 0) nxt[wi] = i_wdata;
    nxt[1][0] = ^nxt[0];
    @(posedge i_clk);
    #1;
    mdl = nxt;
    check_eq("sfr", o_sfr, flat());
    check_eq("rdata", o_rdata, exp_rdata);
    check_eq("rbit", o_rbit, exp_rbit);
    check_eq("rerr", o_rerr, exp_err);
    check_eq("coll", o_coll, exp_coll);
    check_eq("parity", o_parity, ^mdl[0]);
  endtask

  function automatic logic [7:0] pick_addr();
    if ($urandom_range(0, 3) == 0) return 8'($urandom);
    return addr_tbl[$urandom_range(0, NREG-1)];
  endfunction

  function automatic logic [7:0] pick_bit();
    logic [7:0] a;
    if ($urandom_range(0, 5) == 0) return 8'($urandom);
    a = addr_tbl[$urandom_range(0, NREG-1)];
    return {a[7:3], 3'($urandom)};
  endfunction

  initial begin
    addr_tbl = '{8'hE0, 8'hD0, 8'h81, 8'hA8, 8'h89, 8'h88,
                 8'h8A, 8'h8C, 8'h98, 8'h99, 8'hA0, 8'hF0};
    rst_tbl  = '{8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00};
    idle();
    repeat (2) @(posedge i_clk);
    #1;
    model_reset();
    check_eq("rst_sfr", o_sfr, flat());
    check_eq("rst_sp", o_sfr[23:16], 8'h07);
    check_eq("rst_p2", o_sfr[87:80], 8'hFF);
    check_eq("rst_psw", o_sfr[15:8], 8'h00);
    check_eq("rst_rdata", o_rdata, 8'h00);
    check_eq("rst_rerr", o_rerr, 1'b0);
    check_eq("rst_coll", o_coll, 1'b0);
    i_rst = 1'b1;
    step();

    // ACC write drives PSW.P and o_parity
    i_we = 1'b1; i_waddr = 8'hE0; i_wdata = 8'h07;
    step(); idle();
    check_eq("psw_p", o_sfr[15:8], 8'h01);
    check_eq("par_lit", o_parity, 1'b1);
    step();
    check_eq("rd_acc", o_rdata, 8'h07);

    // SETB then CPL on PSW.5 with ACC even parity
    i_we = 1'b1; i_waddr = 8'hE0; i_wdata = 8'h00;
    step(); idle();
    i_bop = 2'b01; i_baddr = 8'hD5;
    step(); idle();
    check_eq("setb_psw", o_sfr[15:8], 8'h20);
    i_bop = 2'b11; i_baddr = 8'hD5;
    step(); idle();
    check_eq("cpl_psw", o_sfr[15:8], 8'h00);

    // Bit op on an unmapped byte
    i_bop = 2'b01; i_baddr = 8'hB8;
    step(); idle();
    check_eq("bop_unmapped_err", o_rerr, 1'b1);
    step();

    // Byte write + bit op + hw update on TCON together
    i_we = 1'b1; i_waddr = 8'h88; i_wdata = 8'h10;
    i_bop = 2'b10; i_baddr = 8'h8C;
    i_hw_we[5] = 1'b1; i_hw_data[47:40] = 8'hFF;
    step(); idle();
    check_eq("coll_tcon", o_sfr[47:40], 8'h10);
    check_eq("coll_pulse", o_coll, 1'b1);
    step();

    // Unmapped read, unmapped write, then all ports erroring at once
    i_raddr = 8'hB5;
    step(); idle();
    check_eq("rd_unmapped", o_rdata, 8'h00);
    i_we = 1'b1; i_waddr = 8'hB5; i_wdata = 8'h55;
    step(); idle();
    i_we = 1'b1; i_waddr = 8'hB5; i_raddr = 8'hB5; i_rbaddr = 8'h80;
    i_bop = 2'b01; i_baddr = 8'hB8;
    step(); idle();
    step();

    for (int n = 0; n < 500; n++) begin
      i_we      = 1'($urandom_range(0, 1));
      i_waddr   = pick_addr();
      i_wdata   = 8'($urandom);
      i_bop     = 2'($urandom_range(0, 3));
      i_baddr   = pick_bit();
      i_raddr   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : addr_tbl[$urandom_range(0, NREG-1)];
      i_rbaddr  = pick_bit();
      i_hw_we   = NREG'($urandom & $urandom);
      i_hw_data = {$urandom, $urandom, $urandom};
      step();
    end

    // Asynchronous reset in the middle of a write cycle
    i_we = 1'b1; i_waddr = 8'hE0; i_wdata = 8'h5A; i_hw_we = '1;
    #2 i_rst = 1'b0;
    #1;
    model_reset();
    check_eq("arst_sfr", o_sfr, flat());
    check_eq("arst_rdata", o_rdata, 8'h00);
    check_eq("arst_rerr", o_rerr, 1'b0);
    check_eq("arst_coll", o_coll, 1'b0);
    @(posedge i_clk);
    #1;
    check_eq("arst_hold", o_sfr, flat());
    idle();
    i_rst = 1'b1;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
